// File: rtl/m_dmux4way16_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : m_dmux4way16_stream                                             |
// | Purpose  : Registered 4-way, 16-bit stream demultiplexer with valid/ready  |
// |            handshaking. One producer stream is steered by i_sel to one of  |
// |            four independent channels. Each channel has a one-entry holding |
// |            register and a saturating delivered-word counter.               |
// | Ports    : i_clk, i_rst_n           clock, async active-low reset          |
// |            i_data, i_sel, i_valid   producer word, destination, present    |
// |            o_ready                  producer word accepted this cycle      |
// |            o_a..o_d, o_valid        channel holding registers and valids   |
// |            i_ready                  per-channel consumer ready             |
// |            o_cnt_a..o_cnt_d         per-channel delivered-word counters    |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module m_dmux4way16_stream #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [15:0]      i_data,
    input  logic [1:0]       i_sel,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [15:0]      o_a,
    output logic [15:0]      o_b,
    output logic [15:0]      o_c,
    output logic [15:0]      o_d,
    output logic [3:0]       o_valid,
    input  logic [3:0]       i_ready,
    output logic [CNT_W-1:0] o_cnt_a,
    output logic [CNT_W-1:0] o_cnt_b,
    output logic [CNT_W-1:0] o_cnt_c,
    output logic [CNT_W-1:0] o_cnt_d
);

    localparam logic [0:0]       c_st_empty = 1'b0;
    localparam logic [0:0]       c_st_full  = 1'b1;
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;

    logic [3:0]       w_valid;
    logic             w_ready;
    logic [15:0]      r_data [4];
    logic [CNT_W-1:0] r_cnt  [4];

    // Only the selected channel can block the producer; a FULL channel whose
    // consumer is ready frees its slot at the same edge, so no bubble.
    assign w_ready = !w_valid[i_sel] || i_ready[i_sel];

    generate
        for (genvar g = 0; g < 4; g++) begin : g_ch
            localparam logic [1:0] c_ch = 2'(g);

            logic [0:0] r_state;
            logic [0:0] w_state_nxt;
            logic       w_in_xfer;
            logic       w_out_xfer;

            assign w_in_xfer  = i_valid && w_ready && (i_sel == c_ch);
            assign w_out_xfer = (r_state == c_st_full) && i_ready[g];

            // A simultaneous load wins over the drain so the channel stays FULL.
            always_comb begin
                w_state_nxt = r_state;
                if (w_in_xfer) begin
                    w_state_nxt = c_st_full;
                end else if (w_out_xfer) begin
                    w_state_nxt = c_st_empty;
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_state <= c_st_empty;
                end else begin
                    r_state <= w_state_nxt;
                end
            end

            // The register keeps its last word while EMPTY; consumers ignore it.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_data[g] <= 16'h0000;
                end else if (w_in_xfer) begin
                    r_data[g] <= i_data;
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_cnt[g] <= '0;
                end else if (w_out_xfer && (r_cnt[g] != c_cnt_max)) begin
                    r_cnt[g] <= r_cnt[g] + 1'b1;
                end
            end

            assign w_valid[g] = (r_state == c_st_full);
        end
    endgenerate

    assign o_ready = w_ready;
    assign o_valid = w_valid;
    assign o_a     = r_data[0];
    assign o_b     = r_data[1];
    assign o_c     = r_data[2];
    assign o_d     = r_data[3];
    assign o_cnt_a = r_cnt[0];
    assign o_cnt_b = r_cnt[1];
    assign o_cnt_c = r_cnt[2];
    assign o_cnt_d = r_cnt[3];

endmodule
`default_nettype wire

// File: doc/m_dmux4way16_stream.md
# m_dmux4way16_stream

Registered 4-way, 16-bit demultiplexer with valid/ready handshaking: the inverse of the 4-way 16-bit selector in the Boolean-logic library. One input word stream is steered to one of four output channels by a 2-bit select. Each channel has a one-entry holding register and a saturating delivered-word counter. It sits between a single producer and four independent consumers in the CPU datapath.

## Interface
- CNT_W, 8, width of each per-channel delivered-word counter.
- i_clk  input  1  rising-edge clock; the only clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_data  input  16  input word.
- i_sel  input  2  destination channel, decoded 0→a, 1→b, 2→c, 3→d; sampled together with i_data.
- i_valid  input  1  input word present.
- o_ready  output  1  block accepts the word this cycle.
- o_a, o_b, o_c, o_d  output  16 each  channel holding registers.
- o_valid  output  4  per-channel word valid; bit 0 is a, bit 3 is d.
- i_ready  input  4  per-channel consumer ready; bit 0 is a, bit 3 is d.
- o_cnt_a, o_cnt_b, o_cnt_c, o_cnt_d  output  CNT_W each  words delivered on the channel.

## Operation
- Channel n has a state of EMPTY or FULL, reflected directly on o_valid[n]. There are four such machines, one per channel, all independent.
- Input transfer happens when i_valid && o_ready at a clock edge.
- Output transfer on channel n happens when o_valid[n] && i_ready[n] at a clock edge.
- o_ready = !o_valid[i_sel] || i_ready[i_sel]. This is combinational in i_sel, i_valid-independent, and depends only on the selected channel.
- On an input transfer to channel n, the data register for n loads i_data and channel n becomes or stays FULL.
- On an output transfer on channel n with no simultaneous input transfer to n, channel n goes to EMPTY.
- Simultaneous output and input transfer on the same channel: the register reloads, the channel stays FULL, and no bubble is inserted.
- Non-selected channels are unaffected by the input side. They drain independently, and several can drain in the same cycle.
- While o_valid[n]=0, the data register for n holds its last value. Consumers must ignore it.
- o_cnt_n increments by 1 on each output transfer on channel n. It saturates at 2^CNT_W−1 and does not wrap.
- i_sel and i_data need only be stable while i_valid is high. The input side may drop or change i_valid without a transfer.

## Timing
- Reset, asynchronous and active-low, drives all outputs immediately: o_valid=4'b0000, o_a through o_d = 16'h0000, all o_cnt_* = 0. While reset is low, o_ready = 1, because all channels are EMPTY.
- Reset asserted mid-operation discards all held words, and counters are cleared. Release is synchronous-safe: first transfer at the first rising edge after i_rst_n goes high.
- Latency: a word accepted at edge k is visible on o_x with o_valid set after edge k, so it can be consumed at edge k+1.
- Throughput: one word per cycle sustained into any channel whose consumer holds i_ready high, including back-to-back words to the same channel.
- A stalled channel (FULL, i_ready low) blocks the input only while i_sel points at it. Switching i_sel to an EMPTY channel restores o_ready in the same cycle.
- No combinational path exists from i_data to any output. o_ready combinationally depends on i_sel, i_ready and state.

## Test plan
- Reset and idle: assert i_rst_n=0 mid-stream with channel b FULL → o_valid=0000, o_b=0000, counts 0, o_ready=1, asynchronously and before the next edge.
- Routing: send 16'h1111/sel 0, 16'h2222/sel 1, 16'h3333/sel 2, 16'h4444/sel 3 with i_ready=0000 → each channel holds its word, o_valid=1111. A 5th word to sel 2 sees o_ready=0.
- Streaming: i_ready=4'b0100, send 100 words 16'h0000..16'h0063 to sel 2 back-to-back → o_ready stays 1, o_c follows with 1-cycle lag in order, o_cnt_c=100.
- Head-of-line independence: channel a stalled FULL, then send to sel 3 → accepted the same cycle. Raise i_ready[0] → a drains, o_cnt_a=1.
- Simultaneous: channel d FULL with 16'hAAAA, i_ready[3]=1, input 16'hBBBB/sel 3 in the same cycle → o_d=BBBB, o_valid[3] stays 1, o_cnt_d increments by 1.
- Saturation: with CNT_W=4, deliver 20 words on channel a → o_cnt_a=15 and holds.
